// File: rtl/ram_latency_model.sv
// ram_latency_model
//
// Behavioural word-addressed RAM with a configurable access latency, sitting
// below the coherence controller. A request on ramREN/ramWEN is latched in IDLE.
// It waits LAT-1 cycles in WAIT and completes with a single ACCESS cycle.
// If the requester changes address, op or write data while the access is in
// flight, the access restarts. If the requester drops the request, the access
// is abandoned and nothing is committed.
//
// Optional feature macro: RAM_ERROR_CHECK_EN
//   defined   : REN&WEN together, or a word index >= DEPTH, gives one ERROR cycle
//   undefined : both high is treated as a write; the index wraps modulo DEPTH
//
// Ports
//   CLK, nRST           clock (rising edge), asynchronous active-low reset
//   ramREN, ramWEN      level read/write requests, held until ACCESS is seen
//   ramaddr, ramstore   byte address (bits [1:0] ignored) and write data
//   ramload             read data, non-zero only during a read ACCESS cycle
//   ramstate            FREE / BUSY / ACCESS / ERROR handshake
//   tbCTRL              bench owns memory; the core port is ignored
//   tbWEN, tbaddr,      zero-latency bench write port
//   tbstore
//   tbload              combinational read of mem[tbaddr[31:2]]

package cpu_types_pkg;
  typedef enum logic [1:0] {
    FREE   = 2'd0,
    BUSY   = 2'd1,
    ACCESS = 2'd2,
    ERROR  = 2'd3
  } ramstate_t;
endpackage

module ram_latency_model #(
  parameter int LAT   = 2,
  parameter int DEPTH = 1024
) (
  input  logic                      CLK,
  input  logic                      nRST,
  input  logic                      ramREN,
  input  logic                      ramWEN,
  input  logic [31:0]               ramaddr,
  input  logic [31:0]               ramstore,
  output logic [31:0]               ramload,
  output cpu_types_pkg::ramstate_t  ramstate,
  input  logic                      tbCTRL,
  input  logic                      tbWEN,
  input  logic [31:0]               tbaddr,
  input  logic [31:0]               tbstore,
  output logic [31:0]               tbload
);
  import cpu_types_pkg::*;

  localparam int         AW       = $clog2(DEPTH);
  localparam logic [3:0] CNT_INIT = 4'(LAT - 1);

  typedef enum logic [1:0] {IDLE, WAIT, ACC, ERR} state_t;

  state_t      state, state_nxt;
  logic [3:0]  cnt, cnt_nxt;
  logic [29:0] idx, idx_nxt;
  logic        op_wr, op_wr_nxt;
  logic [31:0] data, data_nxt;
  logic        commit;

  logic [31:0] mem [DEPTH];

  logic [29:0] live_idx;
  logic        live_wr;
  logic        req;
  logic        req_err;
  logic        changed;

  assign live_idx = ramaddr[31:2];
  // WEN wins when both are high; only the error-check build rejects that case.
  assign live_wr  = ramWEN;
  assign req      = (ramREN | ramWEN) & ~tbCTRL;

`ifdef RAM_ERROR_CHECK_EN
  localparam logic [29:0] DEPTH_IDX = 30'(DEPTH);
  assign req_err = (ramREN & ramWEN) | (live_idx >= DEPTH_IDX);
`else
  assign req_err = 1'b0;
`endif

  // The full 30-bit index is compared. An alias of the same word at a
  // different address still counts as a change and restarts the access.
  assign changed = (live_idx != idx) | (live_wr != op_wr) |
                   (live_wr & op_wr & (ramstore != data));

  assign tbload = mem[tbaddr[AW+1:2]];

  logic unused_addr_bits;
  assign unused_addr_bits = ^{ramaddr[1:0], tbaddr[1:0], tbaddr[31:AW+2]};

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state <= IDLE;
      cnt   <= '0;
      idx   <= '0;
      op_wr <= 1'b0;
      data  <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      idx   <= idx_nxt;
      op_wr <= op_wr_nxt;
      data  <= data_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    idx_nxt   = idx;
    op_wr_nxt = op_wr;
    data_nxt  = data;
    ramstate  = FREE;
    ramload   = '0;
    commit    = 1'b0;

    if (tbCTRL) begin
      // The bench takes over: any in-flight access is dropped uncommitted.
      state_nxt = IDLE;
    end else begin
      unique case (state)
        IDLE: begin
          if (req) begin
            ramstate = BUSY;
            if (req_err) begin
              state_nxt = ERR;
            end else begin
              idx_nxt   = live_idx;
              op_wr_nxt = live_wr;
              data_nxt  = ramstore;
              cnt_nxt   = CNT_INIT;
              state_nxt = (LAT == 1) ? ACC : WAIT;
            end
          end
        end
        WAIT: begin
          ramstate = BUSY;
          if (!ramREN && !ramWEN) begin
            state_nxt = IDLE;
          end else if (changed) begin
            if (req_err) begin
              state_nxt = ERR;
            end else begin
              idx_nxt   = live_idx;
              op_wr_nxt = live_wr;
              data_nxt  = ramstore;
              cnt_nxt   = CNT_INIT;
            end
          end else begin
            cnt_nxt = cnt - 4'd1;
            if (cnt == 4'd1) state_nxt = ACC;
          end
        end
        ACC: begin
          ramstate  = ACCESS;
          state_nxt = IDLE;
          if (op_wr) commit  = 1'b1;
          else       ramload = mem[idx[AW-1:0]];
        end
        ERR: begin
          ramstate  = ERROR;
          state_nxt = IDLE;
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  // The memory array has no reset. The bench port only writes while it owns
  // the memory. A core write only commits in ACC with tbCTRL low, so the two
  // write paths never collide.
  always_ff @(posedge CLK) begin
    if (tbCTRL && tbWEN)
      mem[tbaddr[AW+1:2]] <= tbstore;
    else if (commit)
      mem[idx[AW-1:0]] <= data;
  end

endmodule

// File: tb/tb_ram_latency_model.sv
// tb_ram_latency_model
//
// Directed bench for ram_latency_model with LAT=2 and DEPTH=1024. The bench
// drives inputs 1 time unit after each rising edge and checks the outputs
// before the next edge. Expected values are hand-derived constants.

module tb_ram_latency_model;
  import cpu_types_pkg::*;

  localparam int LAT   = 2;
  localparam int DEPTH = 1024;

  logic        CLK = 1'b0;
  logic        nRST;
  logic        ramREN, ramWEN;
  logic [31:0] ramaddr, ramstore, ramload;
  ramstate_t   ramstate;
  logic        tbCTRL, tbWEN;
  logic [31:0] tbaddr, tbstore, tbload;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  int t_acc0, t_acc1;

  ram_latency_model #(.LAT(LAT), .DEPTH(DEPTH)) dut (
    .CLK      (CLK),
    .nRST     (nRST),
    .ramREN   (ramREN),
    .ramWEN   (ramWEN),
    .ramaddr  (ramaddr),
    .ramstore (ramstore),
    .ramload  (ramload),
    .ramstate (ramstate),
    .tbCTRL   (tbCTRL),
    .tbWEN    (tbWEN),
    .tbaddr   (tbaddr),
    .tbstore  (tbstore),
    .tbload   (tbload)
  );

  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic preload(input logic [31:0] a, input logic [31:0] d);
    tbCTRL = 1'b1; tbWEN = 1'b1; tbaddr = a; tbstore = d;
    tick();
    tbWEN = 1'b0; tbCTRL = 1'b0;
  endtask

  task automatic peek(input string tag, input logic [31:0] a, input logic [31:0] exp);
    tbaddr = a;
    #1;
    check(tag, tbload, exp);
  endtask

  // One complete access: BUSY for LAT cycles, then one ACCESS cycle. The
  // request is dropped in the cycle after ACCESS, which must then read FREE.
  task automatic access(input string tag, input logic wr, input logic [31:0] a,
                        input logic [31:0] d, input logic [31:0] exp_load);
    ramWEN = wr; ramREN = ~wr; ramaddr = a; ramstore = d;
    #1;
    check({tag, " busy idle"}, 32'(ramstate), 32'(BUSY));
    for (int i = 1; i < LAT; i++) begin
      tick();
      check({tag, " busy wait"}, 32'(ramstate), 32'(BUSY));
    end
    tick();
    check({tag, " access"}, 32'(ramstate), 32'(ACCESS));
    check({tag, " load"}, ramload, exp_load);
    tick();
    ramREN = 1'b0; ramWEN = 1'b0;
    #1;
    check({tag, " free"}, 32'(ramstate), 32'(FREE));
  endtask

  initial begin
    nRST = 1'b0; ramREN = 1'b0; ramWEN = 1'b0; ramaddr = '0; ramstore = '0;
    tbCTRL = 1'b0; tbWEN = 1'b0; tbaddr = '0; tbstore = '0;
    tick();
    check("reset state", 32'(ramstate), 32'(FREE));
    check("reset load", ramload, 32'h0);
    tick();
    nRST = 1'b1;
    tick();
    check("post reset state", 32'(ramstate), 32'(FREE));

    // Preload and read
    preload(32'h40, 32'hDEADBEEF);
    access("rd40", 1'b0, 32'h40, 32'h0, 32'hDEADBEEF);

    // Write then read back through both ports
    access("wr80", 1'b1, 32'h80, 32'h12345678, 32'h0);
    access("rd80", 1'b0, 32'h80, 32'h0, 32'h12345678);
    peek("tbload 80", 32'h80, 32'h12345678);

    // Abort-and-restart: address moves during WAIT
    preload(32'h100, 32'h11111111);
    preload(32'h104, 32'h0);
    ramWEN = 1'b1; ramaddr = 32'h100; ramstore = 32'hAAAA;
    #1;
    check("abort busy0", 32'(ramstate), 32'(BUSY));
    tick();
    check("abort busy1", 32'(ramstate), 32'(BUSY));
    ramaddr = 32'h104;
    #1;
    check("restart busy0", 32'(ramstate), 32'(BUSY));
    tick();
    check("restart busy1", 32'(ramstate), 32'(BUSY));
    tick();
    check("restart access", 32'(ramstate), 32'(ACCESS));
    tick();
    ramWEN = 1'b0;
    #1;
    check("restart free", 32'(ramstate), 32'(FREE));
    peek("abort 100 kept", 32'h100, 32'h11111111);
    peek("abort 104 written", 32'h104, 32'hAAAA);

    // Held REN across two fetches
    preload(32'h0, 32'hA0A0A0A0);
    preload(32'h4, 32'hB1B1B1B1);
    ramREN = 1'b1; ramaddr = 32'h0;
    tick();
    tick();
    check("fetch0 access", 32'(ramstate), 32'(ACCESS));
    check("fetch0 load", ramload, 32'hA0A0A0A0);
    t_acc0 = cyc;
    tick();
    ramaddr = 32'h4;
    #1;
    check("fetch1 busy", 32'(ramstate), 32'(BUSY));
    tick();
    tick();
    check("fetch1 access", 32'(ramstate), 32'(ACCESS));
    check("fetch1 load", ramload, 32'hB1B1B1B1);
    t_acc1 = cyc;
    check("fetch spacing", 32'(t_acc1 - t_acc0), 32'd3);
    tick();
    ramREN = 1'b0;
    #1;
    check("fetch free", 32'(ramstate), 32'(FREE));

    // Both requests high, and an out-of-range address
    preload(32'h200, 32'h77777777);
`ifdef RAM_ERROR_CHECK_EN
    ramREN = 1'b1; ramWEN = 1'b1; ramaddr = 32'h200; ramstore = 32'h5555;
    #1;
    tick();
    check("both error", 32'(ramstate), 32'(ERROR));
    ramREN = 1'b0; ramWEN = 1'b0;
    tick();
    check("both error free", 32'(ramstate), 32'(FREE));
    peek("both mem kept", 32'h200, 32'h77777777);
    ramREN = 1'b1; ramaddr = DEPTH * 4;
    #1;
    tick();
    check("range error", 32'(ramstate), 32'(ERROR));
    check("range load", ramload, 32'h0);
    ramREN = 1'b0;
    tick();
    check("range free", 32'(ramstate), 32'(FREE));
`else
    ramREN = 1'b1; ramWEN = 1'b1; ramaddr = 32'h200; ramstore = 32'h5555;
    #1;
    check("both busy", 32'(ramstate), 32'(BUSY));
    tick();
    check("both busy wait", 32'(ramstate), 32'(BUSY));
    tick();
    check("both access", 32'(ramstate), 32'(ACCESS));
    check("both load", ramload, 32'h0);
    tick();
    ramREN = 1'b0; ramWEN = 1'b0;
    #1;
    check("both free", 32'(ramstate), 32'(FREE));
    peek("both as write", 32'h200, 32'h5555);
    access("wrap", 1'b0, DEPTH * 4, 32'h0, 32'hA0A0A0A0);
`endif

    // tbCTRL aborts an in-flight access and suppresses a core write
    ramREN = 1'b1; ramaddr = 32'h40;
    tick();
    tbCTRL = 1'b1;
    #1;
    check("tbctrl free", 32'(ramstate), 32'(FREE));
    tick();
    check("tbctrl idle", 32'(ramstate), 32'(FREE));
    check("tbctrl load", ramload, 32'h0);
    tbCTRL = 1'b0; ramREN = 1'b0;
    preload(32'h380, 32'h38);
    tbCTRL = 1'b1; tbWEN = 1'b1; tbaddr = 32'h384; tbstore = 32'hCAFE;
    ramWEN = 1'b1; ramaddr = 32'h380; ramstore = 32'hBAD;
    #1;
    check("sim write free", 32'(ramstate), 32'(FREE));
    tick();
    tbWEN = 1'b0;
    tick();
    tick();
    ramWEN = 1'b0; tbCTRL = 1'b0;
    peek("sim core blocked", 32'h380, 32'h38);
    peek("sim bench write", 32'h384, 32'hCAFE);

    // Reset during WAIT of a write
    preload(32'h300, 32'h33333333);
    ramWEN = 1'b1; ramaddr = 32'h300; ramstore = 32'h99;
    tick();
    check("rst wait busy", 32'(ramstate), 32'(BUSY));
    nRST = 1'b0; ramWEN = 1'b0;
    #1;
    check("rst free", 32'(ramstate), 32'(FREE));
    tick();
    tick();
    nRST = 1'b1;
    tick();
    check("rst after free", 32'(ramstate), 32'(FREE));
    peek("rst mem kept", 32'h300, 32'h33333333);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/ram_latency_model.md
# ram_latency_model

Behavioural RAM with configurable access latency. It sits directly below the coherence controller and consumes its `ramREN`/`ramWEN`/`ramaddr`/`ramstore` bus. It returns `ramload` and a `ramstate` handshake, which the controller watches for ACCESS to release its `iwait`/`dwait`. A side port lets the bench preload and dump memory with no latency.

## Interface
Parameters:
- `LAT`, 2: cycles from request acceptance to the ACCESS cycle; legal range 1..15.
- `DEPTH`, 1024: memory depth in 32-bit words; must be a power of two.

Ports:
- `CLK` in 1: clock, rising edge.
- `nRST` in 1: reset, asynchronous, active-low.
- `ramREN` in 1: read request, level, held until ACCESS is seen.
- `ramWEN` in 1: write request, level, held until ACCESS is seen.
- `ramaddr` in 32: byte address; bits [1:0] ignored; word index = `ramaddr[31:2]`.
- `ramstore` in 32: write data.
- `ramload` out 32: read data, valid only while `ramstate`=ACCESS.
- `ramstate` out 2: `ramstate_t` from `cpu_types_pkg`: FREE, BUSY, ACCESS, ERROR.
- `tbCTRL` in 1: bench owns memory; the core port is ignored.
- `tbWEN` in 1: bench write strobe.
- `tbaddr` in 32: bench byte address.
- `tbstore` in 32: bench write data.
- `tbload` out 32: `mem[tbaddr[31:2]]`, combinational.

## Operation
State machine with states IDLE, WAIT, ACC, ERR. Registers: `cnt` (4 bits), latched word index, latched op (R/W), latched store data.

- **IDLE**
  - `ramstate` = BUSY if (`ramREN`|`ramWEN`) & ~`tbCTRL`, else FREE.
  - On an edge with a valid request: latch index, op and data; `cnt` = `LAT`-1.
  - Next state is ACC if `LAT`=1, otherwise WAIT.
- **WAIT**
  - `ramstate` = BUSY; `cnt` decrements each edge.
  - `cnt`=1 at the edge → ACC.
  - If the live address, op or (for writes) data differs from the latched values: relatch, reload `cnt` = `LAT`-1, stay in WAIT. This abort-and-restart means a dropped or changed request never commits.
  - Both `ramREN` and `ramWEN` low → IDLE, nothing committed.
- **ACC** (exactly one cycle)
  - `ramstate` = ACCESS.
  - Read: `ramload` = `mem[latched index]`.
  - Write: `mem[latched index]` = latched data at the closing edge; `ramload` = 0.
  - Always → IDLE. A request still held in IDLE starts a fresh access; back-to-back accesses cost `LAT`+1 cycles each.
- **ERR** (one cycle): `ramstate` = ERROR; nothing committed; → IDLE.
- **tbCTRL**
  - When `tbCTRL`=1 in any state: go to IDLE, discard any in-flight access, hold `ramstate` = FREE.
  - A `tbWEN` edge writes `mem[tbaddr[31:2]]` = `tbstore`.
- `ramload` = 0 in every state except a read in ACC.

## Timing
- **Reset:** state IDLE, `cnt`=0, latches 0, `ramload`=0, `ramstate`=FREE (no request present). Memory contents are not reset.
- **Read latency:** request accepted at edge k (IDLE) → ACCESS during cycle k+`LAT` → IDLE at k+`LAT`+1.
- **Write commit:** happens at edge k+`LAT`+1.
- **Handshake:** the requester must hold its request stable until the cycle after ACCESS. The controller lowering its request in that cycle is legal and required.
- **Mid-access reset:** asynchronously returns to IDLE; no partial write is performed.
- **Simultaneous bench and core write in the same cycle:** `tbCTRL`=1 suppresses the core, so only the bench write occurs.

## Configuration
- `RAM_ERROR_CHECK_EN` defined:
  - `ramREN`&`ramWEN` in IDLE → ERR.
  - Word index ≥ `DEPTH` in IDLE → ERR.
- `RAM_ERROR_CHECK_EN` undefined:
  - ERR is unreachable; `ramstate` never shows ERROR.
  - Both requests high → treated as a write.
  - Index is taken modulo `DEPTH`.

## Test plan
- **Preload and read:** bench writes `mem[0x40>>2]`=0xDEADBEEF; `tbCTRL`=0; `ramREN`=1, `ramaddr`=0x40, `LAT`=2 → BUSY, BUSY, then ACCESS with `ramload`=0xDEADBEEF, then FREE after REN drops.
- **Write then read:** `ramWEN`=1, `ramaddr`=0x80, `ramstore`=0x12345678; ACCESS after 2 BUSY cycles; then read 0x80 → `ramload`=0x12345678; `tbload` at 0x80 agrees.
- **Abort-and-restart:** write to 0x100 with data 0xAAAA; during WAIT change the address to 0x104 → restart with 2 fresh BUSY cycles; 0x100 unchanged, 0x104=0xAAAA.
- **Held REN across two fetches:** `ramREN` held high, address changes from 0x0 to 0x4 the cycle after ACCESS → two ACCESS pulses exactly `LAT`+1 cycles apart with the correct data.
- **Error checks with `RAM_ERROR_CHECK_EN`:**
  - REN=WEN=1 → one ERROR cycle, memory unchanged.
  - `ramaddr`=`DEPTH`*4 → ERROR.
  - Without the macro: the same address wraps to word 0.
- **Reset mid-WAIT** of a write → `ramstate` FREE immediately and the target word is unchanged.
